// File: rtl/cpu_controller.sv
// Multicycle control FSM for the CPU datapath: fetches an instruction over a req/ready handshake,
// decodes it and sequences register read, execute/writeback and PC increment.
module cpu_controller #(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memReady,
  input  logic [15:0]              memData,
  output logic                     memReq,
  output logic [REG_ADDR_BITS-1:0] regAddressA,
  output logic [REG_ADDR_BITS-1:0] regAddressB,
  output logic [REG_WIDTH-1:0]     immediate,
  output logic [3:0]               aluOpCode,
  output logic                     instrType,
  output logic                     srcAddressRegEnable,
  output logic                     dstAddressRegEnable,
  output logic                     immediateRegEnable,
  output logic                     aluOutputRegEnable,
  output logic                     regWriteEnable,
  output logic                     pcEnable,
  output logic                     aluInputAMuxSelect,
  output logic                     aluInputBMuxSelect,
  output logic                     halted
);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_PC_IMM  = 3'd4,
    ST_PC_INC  = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  state_t      state_r;
  state_t      nextState_s;
  logic [15:0] ir_r;
  logic [15:0] nextIr_s;

  logic                     memReq_s;
  logic [REG_ADDR_BITS-1:0] regAddressA_s;
  logic [REG_ADDR_BITS-1:0] regAddressB_s;
  logic [REG_WIDTH-1:0]     immediate_s;
  logic [3:0]               aluOpCode_s;
  logic                     instrType_s;
  logic                     srcEn_s;
  logic                     dstEn_s;
  logic                     immEn_s;
  logic                     aluOutEn_s;
  logic                     regWe_s;
  logic                     pcEn_s;
  logic                     muxA_s;
  logic                     muxB_s;
  logic                     halted_s;

  logic [3:0]           nextOp_s;
  logic                 isRType_s;
  logic                 isHalt_s;
  logic                 isIType_s;
  logic                 isCmp_s;
  logic [REG_WIDTH-1:0] signExtImm_s;

  // Next-state and instruction-register update
  always_comb begin
    nextState_s = state_r;
    nextIr_s    = ir_r;
    case (state_r)
      ST_RESET: begin
        nextState_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (memReady) begin
          nextIr_s    = memData;
          nextState_s = ST_DECODE;
        end else begin
          nextState_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (ir_r[15:12] == 4'b1111) begin
          nextState_s = ST_HALT;
        end else begin
          nextState_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: nextState_s = ST_PC_IMM;
      ST_PC_IMM:  nextState_s = ST_PC_INC;
      ST_PC_INC:  nextState_s = ST_FETCH;
      ST_HALT:    nextState_s = ST_HALT;
      default:    nextState_s = ST_RESET;
    endcase
  end

  // Instruction classification of the IR value the next cycle will hold
  always_comb begin
    nextOp_s     = nextIr_s[15:12];
    isRType_s    = (nextOp_s == 4'b0000);
    isHalt_s     = (nextOp_s == 4'b1111);
    isIType_s    = !isRType_s && !isHalt_s;
    isCmp_s      = (isRType_s && (nextIr_s[7:4] == 4'b1011)) || (nextOp_s == 4'b1011);
    signExtImm_s = {{(REG_WIDTH-8){nextIr_s[7]}}, nextIr_s[7:0]};
  end

  // Moore output decode for the upcoming state; registered below so outputs are glitch-free
  always_comb begin
    memReq_s      = 1'b0;
    regAddressA_s = nextIr_s[REG_ADDR_BITS-1:0];
    regAddressB_s = nextIr_s[8 +: REG_ADDR_BITS];
    immediate_s   = {REG_WIDTH{1'b0}};
    aluOpCode_s   = 4'b0000;
    instrType_s   = 1'b0;
    srcEn_s       = 1'b0;
    dstEn_s       = 1'b0;
    immEn_s       = 1'b0;
    aluOutEn_s    = 1'b0;
    regWe_s       = 1'b0;
    pcEn_s        = 1'b0;
    muxA_s        = 1'b0;
    muxB_s        = 1'b0;
    halted_s      = 1'b0;
    case (nextState_s)
      ST_FETCH: begin
        memReq_s = 1'b1;
      end
      ST_DECODE: begin
        srcEn_s     = 1'b1;
        dstEn_s     = 1'b1;
        immEn_s     = isIType_s;
        immediate_s = isIType_s ? signExtImm_s : {REG_WIDTH{1'b0}};
      end
      ST_EXECUTE: begin
        muxB_s      = isIType_s;
        aluOpCode_s = isRType_s ? nextIr_s[7:4] : nextOp_s;
        instrType_s = isIType_s;
        immediate_s = isIType_s ? signExtImm_s : {REG_WIDTH{1'b0}};
        aluOutEn_s  = 1'b1;
        regWe_s     = !isCmp_s;
      end
      ST_PC_IMM: begin
        immediate_s = {{(REG_WIDTH-1){1'b0}}, 1'b1};
        immEn_s     = 1'b1;
      end
      ST_PC_INC: begin
        muxA_s      = 1'b1;
        muxB_s      = 1'b1;
        aluOpCode_s = 4'b0101;
        instrType_s = 1'b1;
        pcEn_s      = 1'b1;
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        regAddressA_s = {REG_ADDR_BITS{1'b0}};
        regAddressB_s = {REG_ADDR_BITS{1'b0}};
      end
    endcase
  end

  // State, IR and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r             <= ST_RESET;
      ir_r                <= 16'h0000;
      memReq              <= 1'b0;
      regAddressA         <= {REG_ADDR_BITS{1'b0}};
      regAddressB         <= {REG_ADDR_BITS{1'b0}};
      immediate           <= {REG_WIDTH{1'b0}};
      aluOpCode           <= 4'b0000;
      instrType           <= 1'b0;
      srcAddressRegEnable <= 1'b0;
      dstAddressRegEnable <= 1'b0;
      immediateRegEnable  <= 1'b0;
      aluOutputRegEnable  <= 1'b0;
      regWriteEnable      <= 1'b0;
      pcEnable            <= 1'b0;
      aluInputAMuxSelect  <= 1'b0;
      aluInputBMuxSelect  <= 1'b0;
      halted              <= 1'b0;
    end else begin
      state_r             <= nextState_s;
      ir_r                <= nextIr_s;
      memReq              <= memReq_s;
      regAddressA         <= regAddressA_s;
      regAddressB         <= regAddressB_s;
      immediate           <= immediate_s;
      aluOpCode           <= aluOpCode_s;
      instrType           <= instrType_s;
      srcAddressRegEnable <= srcEn_s;
      dstAddressRegEnable <= dstEn_s;
      immediateRegEnable  <= immEn_s;
      aluOutputRegEnable  <= aluOutEn_s;
      regWriteEnable      <= regWe_s;
      pcEnable            <= pcEn_s;
      aluInputAMuxSelect  <= muxA_s;
      aluInputBMuxSelect  <= muxB_s;
      halted              <= halted_s;
    end
  end

endmodule
